// File: rtl/mybusmatrix_arb_rr_if.sv
// mybusmatrix_arb_rr_if: request/transfer inputs and grant outputs of one slave-port arbiter
interface mybusmatrix_arb_rr_if;
  logic [7:0] req_port;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [2:0] addr_in_port;
  logic       no_port;
  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port
  );
  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port
  );
endinterface

// File: rtl/mybusmatrix_arb_rr.sv
// mybusmatrix_arb_rr: round-robin AHB output arbiter; MYBUSMATRIX_ARB_MAXHOLD_EN adds an INCR max-hold yield
module mybusmatrix_arb_rr #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8
) (
  input logic HCLK,
  input logic HRESET,
  mybusmatrix_arb_rr_if.slave bus
);
  logic [2:0] r_addr;
  logic       r_nop;
  logic [2:0] w_addr_nx;
  logic       w_nop_nx;
  logic [7:0] w_req;
  logic       w_any;
  logic       w_others;
  logic       w_owner_active;
  logic       w_seq;
  logic       w_yield;
  logic       w_keep;
  logic       w_search;
  logic       w_found;
  logic [2:0] w_pick;
  assign w_req          = bus.req_port & 8'((1 << NUM_PORTS) - 1);
  assign w_any          = |w_req;
  assign w_others       = |(w_req & ~(8'd1 << r_addr));
  assign w_owner_active = bus.HSELM & (bus.HTRANSM != 2'b00);
  assign w_seq          = bus.HSELM & (bus.HTRANSM == 2'b11);
`ifdef MYBUSMATRIX_ARB_MAXHOLD_EN
  logic [7:0] r_hold;
  logic       w_hold_clr;
  assign w_yield    = (bus.HBURSTM == 3'b001) & (r_hold >= 8'(MAX_HOLD - 1)) & w_others & !bus.HMASTLOCKM;
  assign w_hold_clr = (w_addr_nx != r_addr) | (bus.HSELM & (bus.HTRANSM == 2'b10)) | w_nop_nx;
  always_ff @(posedge HCLK) begin
    if (HRESET) r_hold <= 8'd0;
    else if (bus.HREADYM) r_hold <= w_hold_clr ? 8'd0 : (w_seq && r_hold < 8'(MAX_HOLD)) ? r_hold + 8'd1 : r_hold;
  end
`else
  logic w_unused;
  assign w_yield  = 1'b0;
  assign w_unused = ^{bus.HBURSTM, w_others};
`endif
  // owner is visited last so a persistent requester cannot starve the others
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_addr;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      logic [2:0] idx;
      idx = 3'((int'(r_addr) + k) % NUM_PORTS);
      if (!w_found && (w_req[idx] || (idx == r_addr && w_owner_active)) && !(w_yield && idx == r_addr)) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end
  assign w_keep    = bus.HMASTLOCKM | (w_seq & !w_yield);
  assign w_search  = w_any | w_owner_active;
  assign w_addr_nx = w_keep ? r_addr : w_search ? w_pick : r_addr;
  assign w_nop_nx  = !(w_keep | w_search | bus.HSELM);
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr <= 3'(NUM_PORTS - 1);
      r_nop  <= 1'b1;
    end else if (bus.HREADYM) begin
      r_addr <= w_addr_nx;
      r_nop  <= w_nop_nx;
    end
  end
  assign bus.addr_in_port = r_addr;
  assign bus.no_port      = r_nop;
endmodule

// File: tb/tb_mybusmatrix_arb_rr.sv
// tb_mybusmatrix_arb_rr: directed and randomized checks of the round-robin arbiter against a rule-level model
module tb_mybusmatrix_arb_rr;
  localparam int NP = 4;
  localparam int MH = 4;
  logic HCLK;
  logic HRESET;
  int checks;
  int errors;
  int m_addr;
  int m_nop;
  int m_hold;
  mybusmatrix_arb_rr_if bus();
  mybusmatrix_arb_rr #(.NUM_PORTS(NP), .MAX_HOLD(MH)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic [7:0] rq, input logic rd, input logic sl,
                      input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    int n_addr, n_nop, n_hold, best, bestd, d;
    logic [7:0] rv;
    logic act, oth, yld, q;
    HRESET = r; bus.req_port = rq; bus.HREADYM = rd; bus.HSELM = sl;
    bus.HTRANSM = tr; bus.HBURSTM = bu; bus.HMASTLOCKM = lk;
    n_addr = m_addr; n_nop = m_nop; n_hold = m_hold;
    if (r) begin
      n_addr = NP - 1; n_nop = 1; n_hold = 0;
    end else if (rd) begin
      rv  = rq & 8'((1 << NP) - 1);
      act = sl && tr != 2'b00;
      oth = (rv & ~(8'd1 << m_addr)) != 0;
`ifdef MYBUSMATRIX_ARB_MAXHOLD_EN
      yld = bu == 3'b001 && m_hold >= MH - 1 && oth && !lk;
`else
      yld = 1'b0;
`endif
      if (lk) n_nop = 0;
      else if (sl && tr == 2'b11 && !yld) n_nop = 0;
      else if (rv != 0 || act) begin
        best = -1; bestd = NP;
        for (int i = 0; i < NP; i++) begin
          q = rv[i] || (i == m_addr && act);
          if (yld && i == m_addr) q = 1'b0;
          d = (i - m_addr - 1 + 2 * NP) % NP;
          if (q && d < bestd) begin best = i; bestd = d; end
        end
        n_addr = best; n_nop = 0;
      end else if (sl) n_nop = 0;
      else n_nop = 1;
      if (n_addr != m_addr || (sl && tr == 2'b10) || n_nop == 1) n_hold = 0;
      else if (sl && tr == 2'b11) n_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
    end
    @(posedge HCLK);
    #1;
    m_addr = n_addr; m_nop = n_nop; m_hold = n_hold;
    chk("model_addr", {5'd0, bus.addr_in_port}, 8'(m_addr));
    chk("model_no_port", {7'd0, bus.no_port}, 8'(m_nop));
  endtask
  initial begin
    logic [2:0] rr_exp [5];
    checks = 0; errors = 0; m_addr = 0; m_nop = 0; m_hold = 0;
    rr_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    step(1, 8'h00, 0, 0, 2'b00, 3'b000, 0);
    step(1, 8'h00, 1, 0, 2'b00, 3'b000, 0);
    chk("reset_addr", {5'd0, bus.addr_in_port}, 8'd3);
    chk("reset_no_port", {7'd0, bus.no_port}, 8'd1);
    step(0, 8'h02, 1, 0, 2'b00, 3'b000, 0);
    chk("first_grant", {5'd0, bus.addr_in_port}, 8'd1);
    chk("first_no_port", {7'd0, bus.no_port}, 8'd0);
    step(0, 8'h00, 1, 0, 2'b00, 3'b000, 0);
    chk("idle_no_port", {7'd0, bus.no_port}, 8'd1);
    step(1, 8'h00, 1, 0, 2'b00, 3'b000, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h0F, 1, 1'(i % 2), (i % 2 == 1) ? 2'b10 : 2'b00, 3'b000, 0);
      chk("round_robin", {5'd0, bus.addr_in_port}, {5'd0, rr_exp[i]});
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h04, 0, 1, 2'b10, 3'b000, 0);
      chk("hready_low_hold", {5'd0, bus.addr_in_port}, 8'd0);
    end
    step(0, 8'h04, 0, 1, 2'b00, 3'b000, 0);
    chk("hready_low_idle", {5'd0, bus.addr_in_port}, 8'd0);
    step(0, 8'h04, 1, 1, 2'b00, 3'b000, 0);
    chk("hready_switch", {5'd0, bus.addr_in_port}, 8'd2);
    step(0, 8'h02, 1, 0, 2'b00, 3'b000, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h09, 1, 1, (i == 0) ? 2'b10 : 2'b11, 3'b001, 1);
      chk("lock_hold", {5'd0, bus.addr_in_port}, 8'd1);
    end
    step(0, 8'h09, 1, 1, 2'b00, 3'b000, 0);
    chk("after_unlock", {5'd0, bus.addr_in_port}, 8'd3);
    step(0, 8'h04, 1, 0, 2'b00, 3'b000, 0);
    step(0, 8'h04, 1, 1, 2'b10, 3'b101, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 8'h05, 1, 1, 2'b11, 3'b101, 0);
      chk("incr8_hold", {5'd0, bus.addr_in_port}, 8'd2);
    end
    step(0, 8'h05, 1, 1, 2'b00, 3'b000, 0);
    chk("incr8_end", {5'd0, bus.addr_in_port}, 8'd0);
    step(0, 8'h01, 1, 1, 2'b10, 3'b001, 0);
`ifdef MYBUSMATRIX_ARB_MAXHOLD_EN
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h09, 1, 1, 2'b11, 3'b001, 0);
      chk("maxhold_yield", {5'd0, bus.addr_in_port}, (i < 3) ? 8'd0 : 8'd3);
    end
    for (int i = 0; i < 6; i++) step(0, 8'h09, 1, 1, 2'b11, 3'b001, 0);
`else
    for (int i = 0; i < 10; i++) begin
      step(0, 8'h09, 1, 1, 2'b11, 3'b001, 0);
      chk("incr_no_yield", {5'd0, bus.addr_in_port}, 8'd0);
    end
`endif
    step(0, 8'h09, 1, 1, 2'b00, 3'b000, 0);
    step(0, 8'hF0, 1, 0, 2'b00, 3'b000, 0);
    chk("tied_off_no_port", {7'd0, bus.no_port}, 8'd1);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, 8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
           2'($urandom), ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom), $urandom_range(0, 7) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
